nihilist_cipher_stream: RTL and testbench

Streaming, parametrised Nihilist-cipher engine built on the fixed 5x5 Polybius square (rows MATEI/BCDFG/HKLNO/PQRSU/VWXYZ; no J).
- Runtime-loadable key of up to KEY_MAX_LEN characters.
- Encrypt or decrypt mode per character.
- valid/ready handshakes on input and output.
- Sits between the byte-stream source (UART/host FIFO) and the result sink in the security datapath.

---
 rtl/nihilist_cipher_stream_if.sv | 32 +++
 rtl/nihilist_cipher_stream.sv | 171 +++++++++++++++++
 tb/tb_nihilist_cipher_stream.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/nihilist_cipher_stream_if.sv
// Handshake and key-load bundle for nihilist_cipher_stream.
// master = stream source / key loader side, slave = cipher engine.
interface nihilist_cipher_stream_if #(
  parameter int KEY_IDX_W = 4
);
  logic                 key_wr_en;
  logic [KEY_IDX_W-1:0] key_wr_addr;
  logic [7:0]           key_wr_data;
  logic                 key_len_wr;
  logic [KEY_IDX_W:0]   key_len;
  logic                 mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_data;
  logic                 out_err;
  logic                 busy;

  modport master (
    output key_wr_en, key_wr_addr, key_wr_data, key_len_wr, key_len,
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err, busy
  );

  modport slave (
    input  key_wr_en, key_wr_addr, key_wr_data, key_len_wr, key_len,
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err, busy
  );
endinterface

// File: rtl/nihilist_cipher_stream.sv
// Streaming Nihilist cipher over the fixed Polybius square
//   MATEI / BCDFG / HKLNO / PQRSU / VWXYZ  (no J)
// One character per IDLE -> CALC -> OUT pass; runtime-loadable key.
// Build option: define CIPHER_CASE_FOLD_EN to fold a-z to upper case
// and J to I for plaintext and key characters.
module nihilist_cipher_stream #(
  parameter int KEY_MAX_LEN = 16,
  parameter int KEY_IDX_W   = $clog2(KEY_MAX_LEN)
) (
  input logic                    clk,
  input logic                    rst,
  nihilist_cipher_stream_if.slave bus
);

  localparam logic [KEY_IDX_W:0] KEY_LEN_MAX = (KEY_IDX_W+1)'(KEY_MAX_LEN);
  localparam logic [KEY_IDX_W:0] KEY_LEN_DEF = (KEY_IDX_W+1)'(9);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  // Square cell code row*10+col for a character, 0 when not in the square.
  function automatic logic [5:0] char_code(input logic [7:0] c);
    logic [7:0] u;
    logic [5:0] r;
    u = c;
`ifdef CIPHER_CASE_FOLD_EN
    if (c >= "a" && c <= "z") u = c - 8'd32;
    if (u == "J") u = "I";
`endif
    case (u)
      "M": r = 6'd11; "A": r = 6'd12; "T": r = 6'd13; "E": r = 6'd14; "I": r = 6'd15;
      "B": r = 6'd21; "C": r = 6'd22; "D": r = 6'd23; "F": r = 6'd24; "G": r = 6'd25;
      "H": r = 6'd31; "K": r = 6'd32; "L": r = 6'd33; "N": r = 6'd34; "O": r = 6'd35;
      "P": r = 6'd41; "Q": r = 6'd42; "R": r = 6'd43; "S": r = 6'd44; "U": r = 6'd45;
      "V": r = 6'd51; "W": r = 6'd52; "X": r = 6'd53; "Y": r = 6'd54; "Z": r = 6'd55;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  // Inverse lookup: cell code to upper-case letter, 0 when not a cell.
  function automatic logic [7:0] cell_char(input logic [7:0] d);
    logic [7:0] r;
    case (d)
      8'd11: r = "M"; 8'd12: r = "A"; 8'd13: r = "T"; 8'd14: r = "E"; 8'd15: r = "I";
      8'd21: r = "B"; 8'd22: r = "C"; 8'd23: r = "D"; 8'd24: r = "F"; 8'd25: r = "G";
      8'd31: r = "H"; 8'd32: r = "K"; 8'd33: r = "L"; 8'd34: r = "N"; 8'd35: r = "O";
      8'd41: r = "P"; 8'd42: r = "Q"; 8'd43: r = "R"; 8'd44: r = "S"; 8'd45: r = "U";
      8'd51: r = "V"; 8'd52: r = "W"; 8'd53: r = "X"; 8'd54: r = "Y"; 8'd55: r = "Z";
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Power-on key "PARASCHIV", padded with 'A'.
  function automatic logic [7:0] def_key(input int i);
    logic [7:0] r;
    case (i)
      0: r = "P"; 1: r = "A"; 2: r = "R"; 3: r = "A"; 4: r = "S";
      5: r = "C"; 6: r = "H"; 7: r = "I"; 8: r = "V";
      default: r = "A";
    endcase
    return r;
  endfunction

  state_t               state;
  logic [7:0]           key_ram [KEY_MAX_LEN];
  logic [KEY_IDX_W:0]   key_len_reg;
  logic [KEY_IDX_W-1:0] key_idx;
  logic [7:0]           in_q, key_q;
  logic                 mode_q;
  logic                 in_ready_q, out_valid_q, out_err_q, busy_q;
  logic [7:0]           out_data_q;

  logic [5:0]           p_code, k_code;
  logic [8:0]           diff;
  logic [7:0]           dec_ch, res_data;
  logic                 res_err;
  logic                 hs_in, cfg_ok, len_ok, addr_ok, idx_last;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.busy      = busy_q;

  assign hs_in    = (state == IDLE) && in_ready_q && bus.in_valid;
  assign cfg_ok   = (state == IDLE) && !out_valid_q;
  assign len_ok   = (bus.key_len != '0) && (bus.key_len <= KEY_LEN_MAX);
  assign addr_ok  = int'(bus.key_wr_addr) < KEY_MAX_LEN;
  assign idx_last = ({1'b0, key_idx} + (KEY_IDX_W+1)'(1)) >= key_len_reg;

  // Cipher datapath on the latched character/key pair, consumed in CALC.
  always_comb begin
    p_code   = char_code(in_q);
    k_code   = char_code(key_q);
    diff     = {1'b0, in_q} - {3'b000, k_code};
    dec_ch   = cell_char(diff[7:0]);
    res_data = 8'h00;
    res_err  = 1'b1;
    if (k_code != 6'd0) begin
      if (!mode_q) begin
        if (p_code != 6'd0) begin
          res_data = {2'b00, p_code} + {2'b00, k_code};
          res_err  = 1'b0;
        end
      end else if (!diff[8] && dec_ch != 8'h00) begin
        res_data = dec_ch;
        res_err  = 1'b0;
      end
    end
  end

  // Control FSM, registered outputs, key storage and key index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      key_idx     <= '0;
      key_len_reg <= KEY_LEN_DEF;
      in_q        <= 8'h00;
      key_q       <= 8'h00;
      mode_q      <= 1'b0;
      for (int i = 0; i < KEY_MAX_LEN; i++) key_ram[i] <= def_key(i);
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (hs_in) begin
            in_q       <= bus.in_data;
            mode_q     <= bus.mode;
            key_q      <= key_ram[key_idx];
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          out_data_q  <= res_data;
          out_err_q   <= res_err;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
            if (!out_err_q) key_idx <= idx_last ? '0 : key_idx + KEY_IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // Key updates only while idle; the character latched above still
      // saw the old key entry.
      if (cfg_ok && bus.key_wr_en && addr_ok) begin
        key_ram[bus.key_wr_addr] <= bus.key_wr_data;
        key_idx                  <= '0;
      end
      if (cfg_ok && bus.key_len_wr && len_ok) begin
        key_len_reg <= bus.key_len;
        key_idx     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nihilist_cipher_stream.sv
// Directed bench for nihilist_cipher_stream: vector table on the default
// key plus hand sequences for key loading, wrap, backpressure and reset.
module tb_nihilist_cipher_stream;

  logic clk, rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  nihilist_cipher_stream_if #(.KEY_IDX_W(4)) bus ();

  nihilist_cipher_stream #(.KEY_MAX_LEN(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [7:0] din;
    logic [7:0] exp_d;
    logic       exp_e;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Full character transfer; mode is flipped after the handshake to show
  // it is only sampled there.
  task automatic xfer(input logic m, input logic [7:0] d,
                      output logic [7:0] od, output logic oe, output int lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    bus.mode = m; bus.in_data = d; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.mode = ~m;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
    od = bus.out_data; oe = bus.out_err;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run(input string name, input logic m, input logic [7:0] d,
                     input int exp_d, input int exp_e);
    logic [7:0] od; logic oe; int lat;
    xfer(m, d, od, oe, lat);
    chk({name, "_data"}, od, exp_d);
    chk({name, "_err"}, oe, exp_e);
  endtask

  task automatic wr_key(input int a, input logic [7:0] c);
    bus.key_wr_en = 1'b1; bus.key_wr_addr = 4'(a); bus.key_wr_data = c;
    @(negedge clk);
    bus.key_wr_en = 1'b0;
  endtask

  task automatic wr_len(input int l);
    bus.key_len_wr = 1'b1; bus.key_len = 5'(l);
    @(negedge clk);
    bus.key_len_wr = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    if (!bus.out_valid) chk("wait_out_timeout", 0, 1);
  endtask

  initial begin
    logic [7:0] od; logic oe; int lat;

    // Default key PARASCHIV: P41 A12 R43 A12 S44 C22 H31 I15 V51
    vt[0]  = '{1'b0, "H",   8'd72, 1'b0};  // 31+41
    vt[1]  = '{1'b0, "E",   8'd26, 1'b0};  // 14+12
    vt[2]  = '{1'b0, "#",   8'd0,  1'b1};  // invalid, idx stays on R
    vt[3]  = '{1'b0, "S",   8'd87, 1'b0};  // 44+43
    vt[4]  = '{1'b1, 8'd24, "A",   1'b0};  // 24-12=12
    vt[5]  = '{1'b1, 8'd99, "Z",   1'b0};  // 99-44=55
    vt[6]  = '{1'b1, 8'd30, 8'd0,  1'b1};  // 30-22=8, row 0
    vt[7]  = '{1'b1, 8'd36, "E",   1'b0};  // 36-22=14
    vt[8]  = '{1'b1, 8'd50, 8'd0,  1'b1};  // 50-31=19, col 9
    vt[9]  = '{1'b0, "Z",   8'd86, 1'b0};  // 55+31
    vt[10] = '{1'b0, "M",   8'd26, 1'b0};  // 11+15
    vt[11] = '{1'b1, 8'd20, 8'd0,  1'b1};  // 20-51 negative
    vt[12] = '{1'b1, 8'd110,8'd0,  1'b1};  // 110-51=59
    vt[13] = '{1'b1, 8'd106,"Z",   1'b0};  // 106-51=55, idx wraps 8->0
    vt[14] = '{1'b0, "A",   8'd53, 1'b0};  // 12+41 after wrap
    vt[15] = '{1'b1, 8'd72, 8'd0,  1'b1};  // 72-12=60, col 0

    rst = 1'b1;
    bus.key_wr_en = 1'b0; bus.key_wr_addr = '0; bus.key_wr_data = 8'h00;
    bus.key_len_wr = 1'b0; bus.key_len = '0; bus.mode = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 16; i++) begin
      xfer(vt[i].m, vt[i].din, od, oe, lat);
      chk($sformatf("vec%0d_data", i), od, vt[i].exp_d);
      chk($sformatf("vec%0d_err", i), oe, vt[i].exp_e);
      chk($sformatf("vec%0d_latency", i), lat, 2);
    end

    // Decrypt after index reset by a length write.
    wr_len(9);
    run("dec_H", 1'b1, 8'd72, "H", 0);
    run("dec_E", 1'b1, 8'd26, "E", 0);

    // Key "PA", length 2: wrap and rejected lengths.
    wr_key(0, "P"); wr_key(1, "A"); wr_len(2);
    run("wrap0", 1'b0, "M", 52, 0);
    run("wrap1", 1'b0, "M", 23, 0);
    run("wrap2", 1'b0, "M", 52, 0);
    wr_len(0);                               // ignored, idx stays 1
    run("len0_ignored", 1'b0, "M", 23, 0);
    run("len_m_idx0", 1'b0, "M", 52, 0);
    wr_len(17);                              // ignored, idx stays 1
    run("len17_ignored", 1'b0, "M", 23, 0);

    // Error does not advance the index.
    wr_len(2);
    run("err_hash", 1'b0, "#", 0, 1);
    run("after_err_H", 1'b0, "H", 72, 0);
    wr_len(2);
    run("dec_10_err", 1'b1, 8'd10, 0, 1);

    // Key write in the same cycle as the input handshake (idx 0, key P).
    wait (bus.in_ready);
    @(negedge clk);
    bus.mode = 1'b0; bus.in_data = "H"; bus.in_valid = 1'b1;
    bus.key_wr_en = 1'b1; bus.key_wr_addr = 4'd0; bus.key_wr_data = "M";
    @(negedge clk);
    bus.in_valid = 1'b0; bus.key_wr_en = 1'b0;
    wait_out();
    chk("same_cycle_old_key", bus.out_data, 72);
    bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;
    run("same_cycle_idx1", 1'b0, "H", 43, 0);
    run("same_cycle_new_key", 1'b0, "H", 42, 0);

    // Invalid key character.
    wr_key(1, "#");
    run("key_M", 1'b0, "H", 42, 0);
    run("key_invalid", 1'b0, "H", 0, 1);
    wr_key(1, "A");

    // Backpressure: result held, input blocked, key write ignored.
    bus.mode = 1'b0; bus.in_data = "H"; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out();
    bus.key_wr_en = 1'b1; bus.key_wr_addr = 4'd0; bus.key_wr_data = "Z";
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_data", bus.out_data, 42);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.key_wr_en = 1'b0;
    chk("bp_busy", bus.busy, 1);
    bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;
    wr_len(2);
    run("bp_key_unchanged", 1'b0, "H", 42, 0);

    // Reset while a result is pending in OUT.
    bus.mode = 1'b0; bus.in_data = "E"; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    run("midrst_default_key0", 1'b0, "H", 72, 0);
    run("midrst_default_key1", 1'b0, "E", 26, 0);

    // Case folding.
    wr_len(9);
`ifdef CIPHER_CASE_FOLD_EN
    run("fold_h", 1'b0, "h", 72, 0);
    run("fold_j", 1'b0, "j", 27, 0);         // I15 + A12
`else
    run("nofold_h", 1'b0, "h", 0, 1);
    run("nofold_J", 1'b0, "J", 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
